// File: rtl/regfile.sv
// Architectural register file with per-register rename tags.
// Resolves two issue-time operands to a value or a ROB dependency, absorbing commits and flushes.
module regfile #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dec_ready,
  input  logic [4:0]           dec_rd,
  input  logic [ROB_WIDTH-1:0] dec_rob_id,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  output logic [31:0]          val1,
  output logic [31:0]          val2,
  output logic                 has_dep1,
  output logic                 has_dep2,
  output logic [ROB_WIDTH-1:0] dep1,
  output logic [ROB_WIDTH-1:0] dep2,
  output logic [ROB_WIDTH-1:0] search_rob_id_1,
  output logic [ROB_WIDTH-1:0] search_rob_id_2,
  input  logic                 search_ready_1,
  input  logic                 search_ready_2,
  input  logic [31:0]          search_val_1,
  input  logic [31:0]          search_val_2,
  input  logic                 commit_ready,
  input  logic [ROB_WIDTH-1:0] commit_rob_id,
  input  logic [4:0]           commit_reg_id,
  input  logic [31:0]          commit_val
);

  logic [31:0]          regs [32];
  logic [ROB_WIDTH-1:0] tag  [32];
  logic [31:0]          busy;

  logic do_commit;
  logic do_issue;

  assign do_commit = rdy_in && commit_ready && (commit_reg_id != 5'd0);
  assign do_issue  = rdy_in && dec_ready && !clear && (dec_rd != 5'd0);

  // Issue is written after commit so it wins when both hit the same register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
      busy <= '0;
    end else begin
      if (do_commit) begin
        regs[commit_reg_id] <= commit_val;
        if (busy[commit_reg_id] && (tag[commit_reg_id] == commit_rob_id))
          busy[commit_reg_id] <= 1'b0;
      end
      if (rdy_in && clear)
        busy <= '0;
      if (do_issue) begin
        busy[dec_rd] <= 1'b1;
        tag[dec_rd]  <= dec_rob_id;
      end
    end
  end

  always_comb begin
    search_rob_id_1 = tag[dec_rs1];
    dep1            = tag[dec_rs1];
    val1            = '0;
    has_dep1        = 1'b0;
    if (dec_rs1 != 5'd0) begin
      if (!busy[dec_rs1])
        val1 = regs[dec_rs1];
      else if (commit_ready && (commit_rob_id == tag[dec_rs1]))
        val1 = commit_val;
      else if (search_ready_1)
        val1 = search_val_1;
      else
        has_dep1 = 1'b1;
    end
  end

  always_comb begin
    search_rob_id_2 = tag[dec_rs2];
    dep2            = tag[dec_rs2];
    val2            = '0;
    has_dep2        = 1'b0;
    if (dec_rs2 != 5'd0) begin
      if (!busy[dec_rs2])
        val2 = regs[dec_rs2];
      else if (commit_ready && (commit_rob_id == tag[dec_rs2]))
        val2 = commit_val;
      else if (search_ready_2)
        val2 = search_val_2;
      else
        has_dep2 = 1'b1;
    end
  end

endmodule
